// File: rtl/dds_ctrl_pkg.sv
// Shared definitions for the DDS sweep controller: register map, MODE bits, FSM states.
package dds_ctrl_pkg;

  localparam logic [2:0] ADDR_START = 3'd0;
  localparam logic [2:0] ADDR_STOP  = 3'd1;
  localparam logic [2:0] ADDR_INC   = 3'd2;
  localparam logic [2:0] ADDR_DWELL = 3'd3;
  localparam logic [2:0] ADDR_MODE  = 3'd4;

  localparam int MODE_LOOP = 0;
  localparam int MODE_TRI  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2
  } state_e;

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable dwell down-counter; a dwell of 0 is treated as 1.
// expire fires in the last enabled cycle of a dwell period.
module dds_dwell_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] dwell,
  output logic         expire
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = (dwell == '0) ? ONE : dwell;
    else if (en && cnt_q > ONE)
      cnt_d = cnt_q - ONE;
  end

  // The counter never sits below 1, so expiry is simply "at 1 while running".
  assign expire = en && (cnt_q <= ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= ONE;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Sequences the DDS step_phase word through static, chirp, sawtooth and triangle sweeps.
// Define SWEEP_PHASE_CLR_EN to add phase_clr for phase-coherent restarts at START.
module dds_sweep_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int PHASE_W = 48,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [2:0]         cfg_addr,
  input  logic [PHASE_W-1:0] cfg_data,
  input  logic               start,
  input  logic               abort,
  output logic [PHASE_W-1:0] step_phase,
  output logic               step_valid,
  output logic               busy,
  output logic               done,
  output logic               dir_down
`ifdef SWEEP_PHASE_CLR_EN
  ,
  output logic               phase_clr
`endif
);

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] start_q, start_d;
  logic [PHASE_W-1:0] stop_q, stop_d;
  logic [PHASE_W-1:0] inc_q, inc_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [1:0]         mode_q, mode_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               dir_q, dir_d;
  logic               wrap_q, wrap_d;
  logic               busy_q, busy_d;
`ifdef SWEEP_PHASE_CLR_EN
  logic               clr_q, clr_d;
`endif

  logic               tmr_load, tmr_en, tmr_expire;
  logic [PHASE_W:0]   sum, dif;

  // One extra bit so carry/borrow past the word width is visible to the limit tests.
  assign sum = {1'b0, phase_q} + {1'b0, inc_q};
  assign dif = {1'b0, phase_q} - {1'b0, inc_q};

  dds_dwell_timer #(.W(DWELL_W)) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .en     (tmr_en),
    .dwell  (dwell_q),
    .expire (tmr_expire)
  );

  always_comb begin
    start_d  = start_q;
    stop_d   = stop_q;
    inc_d    = inc_q;
    dwell_d  = dwell_q;
    mode_d   = mode_q;
    state_d  = state_q;
    phase_d  = phase_q;
    dir_d    = dir_q;
    wrap_d   = wrap_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
`ifdef SWEEP_PHASE_CLR_EN
    clr_d    = 1'b0;
`endif

    if (cfg_valid && cfg_ready) begin
      case (cfg_addr)
        ADDR_START: start_d = cfg_data;
        ADDR_STOP:  stop_d  = cfg_data;
        ADDR_INC:   inc_d   = cfg_data;
        ADDR_DWELL: dwell_d = cfg_data[DWELL_W-1:0];
        ADDR_MODE:  mode_d  = cfg_data[1:0];
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d  = RUN;
          phase_d  = start_q;
          valid_d  = 1'b1;
          dir_d    = 1'b0;
          wrap_d   = 1'b0;
          tmr_load = 1'b1;
`ifdef SWEEP_PHASE_CLR_EN
          clr_d    = 1'b1;
`endif
        end
      end

      RUN: begin
        tmr_en = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (tmr_expire) begin
          tmr_load = 1'b1;
          valid_d  = 1'b1;
          if (wrap_q) begin
            // Sawtooth: the frequency after a STOP clamp restarts at START.
            phase_d = start_q;
            wrap_d  = 1'b0;
`ifdef SWEEP_PHASE_CLR_EN
            clr_d   = 1'b1;
`endif
          end else if (dir_q) begin
            if (dif[PHASE_W] || dif <= {1'b0, start_q}) begin
              phase_d = start_q;
              dir_d   = 1'b0;
            end else begin
              phase_d = dif[PHASE_W-1:0];
            end
          end else if (sum >= {1'b0, stop_q}) begin
            phase_d = stop_q;
            if (!mode_q[MODE_LOOP])    state_d = FINAL;
            else if (mode_q[MODE_TRI]) dir_d   = 1'b1;
            else                       wrap_d  = 1'b1;
          end else begin
            phase_d = sum[PHASE_W-1:0];
          end
        end
      end

      FINAL: begin
        tmr_en = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (tmr_expire) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= '0;
      stop_q  <= '0;
      inc_q   <= '0;
      dwell_q <= DWELL_W'(1);
      mode_q  <= '0;
      phase_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SWEEP_PHASE_CLR_EN
      clr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      inc_q   <= inc_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
      phase_q <= phase_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
`ifdef SWEEP_PHASE_CLR_EN
      clr_q   <= clr_d;
`endif
    end
  end

  assign cfg_ready  = !busy_q;
  assign step_phase = phase_q;
  assign step_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign dir_down   = dir_q;
`ifdef SWEEP_PHASE_CLR_EN
  assign phase_clr  = clr_q;
`endif

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: the sweep is modelled as a list of frequencies, each held DWELL cycles.
module tb_dds_sweep_ctrl;

  localparam longint unsigned PMAX = 64'h0001_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid, cfg_ready;
  logic [2:0]  cfg_addr;
  logic [47:0] cfg_data;
  logic        start, abort;
  logic [47:0] step_phase;
  logic        step_valid, busy, done, dir_down;
`ifdef SWEEP_PHASE_CLR_EN
  logic        phase_clr;
`endif

  dds_sweep_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .start      (start),
    .abort      (abort),
    .step_phase (step_phase),
    .step_valid (step_valid),
    .busy       (busy),
    .done       (done),
    .dir_down   (dir_down)
`ifdef SWEEP_PHASE_CLR_EN
    ,
    .phase_clr  (phase_clr)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Shadow of the programmed registers
  longint unsigned m_start, m_stop, m_inc;
  int              m_dwell;
  logic [1:0]      m_mode;

  // Model: frequency list of the sweep, direction and phase-restart flag per entry
  longint unsigned vals[$];
  bit              dirs[$];
  bit              clrs[$];
  int              L, D;

  logic [47:0] e_phase, last_phase;
  bit          e_valid, e_busy, e_done, e_dir, e_clr, chk_en;

  longint unsigned p_os[4]  = '{100, 110, 120, 130};
  longint unsigned p_cl[4]  = '{100, 110, 120, 125};
  longint unsigned p_tri[6] = '{0, 10, 20, 10, 0, 10};
  bit              p_trd[6] = '{0, 0, 1, 1, 0, 0};

  always @(negedge clk) begin
    if (chk_en) begin
      chk("step_phase", step_phase, e_phase);
      chk("step_valid", step_valid, e_valid);
      chk("busy", busy, e_busy);
      chk("cfg_ready", cfg_ready, !e_busy);
      chk("done", done, e_done);
      if (e_busy) chk("dir_down", dir_down, e_dir);
`ifdef SWEEP_PHASE_CLR_EN
      chk("phase_clr", phase_clr, e_clr);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    e_busy = 0; e_valid = 0; e_done = 0; e_clr = 0; e_phase = last_phase;
  endtask

  task automatic reset_shadow();
    m_start = 0; m_stop = 0; m_inc = 0; m_dwell = 1; m_mode = 2'd0;
  endtask

  task automatic cfg_write(input int a, input longint unsigned d);
    cfg_valid = 1; cfg_addr = 3'(a); cfg_data = 48'(d);
    tick();
    cfg_valid = 0;
    case (a)
      0: m_start = d;
      1: m_stop  = d;
      2: m_inc   = d;
      3: m_dwell = int'(d & 64'hFFFF);
      4: m_mode  = 2'(d);
      default: ;
    endcase
  endtask

  task automatic cfg_all(input longint unsigned s, input longint unsigned p, input longint unsigned i,
                         input int dw, input int md);
    cfg_write(0, s); cfg_write(1, p); cfg_write(2, i); cfg_write(3, longint'(dw)); cfg_write(4, longint'(md));
  endtask

  // Builds the frequency list from the register rules; L = entry count of a finished one-shot, else -1.
  task automatic gen(input int maxn);
    longint unsigned v, n;
    bit lp, tr, down, wrap, c;
    lp = m_mode[0]; tr = m_mode[1] && lp;
    vals.delete(); dirs.delete(); clrs.delete();
    L = -1; down = 0; wrap = 0;
    v = m_start;
    vals.push_back(v); dirs.push_back(1'b0); clrs.push_back(1'b1);
    while (vals.size() < maxn && L < 0) begin
      c = 0;
      if (wrap) begin
        v = m_start; wrap = 0; c = 1;
      end else if (down) begin
        if (v < m_inc || v - m_inc <= m_start) begin v = m_start; down = 0; end
        else v = v - m_inc;
      end else begin
        n = v + m_inc;
        if (n >= m_stop) begin
          v = m_stop;
          if (!lp)     L = vals.size() + 1;
          else if (tr) down = 1;
          else         wrap = 1;
        end else begin
          v = n;
        end
      end
      vals.push_back(v); dirs.push_back(down); clrs.push_back(c);
    end
  endtask

  task automatic run_sweep(input int ncyc, input int abort_k_in, input bit hold_cfg,
                           input longint unsigned hold_data);
    int n, idx, abort_k;
    bit eff;
    logic [47:0] abp;
    abort_k = abort_k_in;
    D = (m_dwell == 0) ? 1 : m_dwell;
    gen(ncyc / D + 3);
    n = (L > 0) ? L * D + 3 : ncyc;
    if (L < 0 && abort_k == 0) abort_k = ncyc - 1;
    if (abort_k + 2 > n) n = abort_k + 2;
    eff = (abort_k > 0) && (L < 0 || abort_k <= L * D);
    abp = '0;
    start = 1;
    tick();
    start = 0;
    for (int k = 1; k <= n; k++) begin
      if (eff && k > abort_k) begin
        e_busy = 0; e_valid = 0; e_done = 0; e_clr = 0; e_phase = abp;
      end else if (L > 0 && k > L * D) begin
        e_busy = 0; e_valid = 0; e_clr = 0; e_done = (k == L * D + 1); e_phase = 48'(vals[L-1]);
      end else begin
        idx = (k - 1) / D;
        e_busy = 1; e_done = 0; e_phase = 48'(vals[idx]);
        e_valid = ((k - 1) % D == 0); e_dir = dirs[idx]; e_clr = e_valid && clrs[idx];
      end
      if (k == abort_k) abp = e_phase;
      abort = (k == abort_k);
      if (hold_cfg && k == 1) begin cfg_addr = 3'd0; cfg_data = 48'(hold_data); cfg_valid = 1; end
      if (hold_cfg && k == abort_k + 2) begin cfg_valid = 0; m_start = hold_data; end
      tick();
    end
    abort = 0;
    last_phase = e_phase;
    set_idle();
  endtask

  initial begin
    longint unsigned rs, rp, ri;
    int rk;
    cfg_valid = 0; cfg_addr = '0; cfg_data = '0; start = 0; abort = 0; chk_en = 0;
    reset_shadow(); last_phase = '0;
    #3;
    chk("rst_phase", step_phase, 0);
    chk("rst_valid", step_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dir", dir_down, 0);
    chk("rst_ready", cfg_ready, 1);
    tick();
    rst_n = 1;
    set_idle(); chk_en = 1;
    tick(); tick();

    // one-shot chirp
    cfg_all(100, 130, 10, 3, 0);
    gen(20);
    for (int i = 0; i < 4; i++) chk("pin_oneshot", vals[i], p_os[i]);
    chk("pin_oneshot_done_cyc", longint'(L * 3 + 1), 13);
    run_sweep(60, 0, 0, 0);
    chk("oneshot_hold", step_phase, 130);

    // clamp to STOP
    cfg_all(100, 125, 10, 1, 0);
    gen(20);
    for (int i = 0; i < 4; i++) chk("pin_clamp", vals[i], p_cl[i]);
    run_sweep(60, 0, 0, 0);

    // triangle
    cfg_all(0, 20, 10, 1, 3);
    gen(8);
    for (int i = 0; i < 6; i++) begin
      chk("pin_tri", vals[i], p_tri[i]);
      chk("pin_tri_dir", longint'(dirs[i]), longint'(p_trd[i]));
    end
    run_sweep(20, 0, 0, 0);

    // carry out of the word clamps to STOP
    cfg_all(PMAX - 20, PMAX - 1, 32, 1, 0);
    gen(8);
    chk("pin_ovf_len", longint'(L), 2);
    chk("pin_ovf_last", vals[1], PMAX - 1);
    run_sweep(20, 0, 0, 0);

    // config held during a sawtooth run is stalled until IDLE
    cfg_all(10, 40, 10, 1, 1);
    run_sweep(30, 12, 1, 777);
    cfg_write(4, 0);
    gen(8);
    chk("pin_stalled_start", vals[0], 777);
    run_sweep(20, 0, 0, 0);
    chk("stalled_write_used", step_phase, 40);

    // start+abort collision
    start = 1; abort = 1;
    tick();
    start = 0; abort = 0;
    repeat (3) tick();
    chk("collision_busy", busy, 0);

    // abort mid-run at 110
    cfg_all(100, 130, 10, 3, 0);
    run_sweep(40, 5, 0, 0);
    chk("abort_hold", step_phase, 110);

    // randomized sweeps
    for (int it = 0; it < 16; it++) begin
      cfg_write($urandom_range(5, 7), {$urandom, $urandom} & (PMAX - 1));
      if ($urandom_range(0, 3) == 0) begin
        rs = PMAX - $urandom_range(1, 100);
        rp = PMAX - $urandom_range(1, 50);
        ri = $urandom_range(0, 60);
      end else begin
        rs = $urandom_range(0, 200);
        rp = $urandom_range(0, 300);
        ri = $urandom_range(0, 40);
      end
      cfg_all(rs, rp, ri, $urandom_range(0, 3), $urandom_range(0, 3));
      rk = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0;
      run_sweep(50, rk, 0, 0);
      tick();
    end

    // reset in the middle of a run
    cfg_all(100, 130, 10, 3, 0);
    chk_en = 0;
    start = 1;
    tick();
    start = 0;
    repeat (4) tick();
    chk("midrun_busy", busy, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_phase", step_phase, 0);
    chk("mid_rst_valid", step_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_dir", dir_down, 0);
    chk("mid_rst_ready", cfg_ready, 1);
`ifdef SWEEP_PHASE_CLR_EN
    chk("mid_rst_clr", phase_clr, 0);
`endif
    reset_shadow(); last_phase = '0;
    tick();
    rst_n = 1;
    set_idle(); chk_en = 1;
    tick();
    // registers back at reset values: START=STOP=0 gives 0, clamp 0, done
    run_sweep(10, 0, 0, 0);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
